// File: rtl/ham_scan_pkg.sv
// Shared types and constants for the Hamming-distance scan sequencer.
// Contents: state enum, distance-width helper, default placement constants.
package ham_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        CMP,
        WRITE,
        DONE
    } state_t;

    localparam int BASE_DEF        = 128;
    localparam int COUNT_DEF       = 20;
    localparam int RESULT_ADDR_DEF = 127;

    // Bits needed to hold a distance in 0..dw.
    function automatic int hw_of(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/ham_scan_ctrl_if.sv
// Data-memory port owned by the scan sequencer while it is busy.
// Signals: MemAddr, MemWrEn, MemWrData (sequencer -> memory),
//          MemRdData (memory -> sequencer, combinational read).
// Modports: master = sequencer side, slave = memory side.
interface ham_scan_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemRdData;
    logic          MemWrEn;
    logic [DW-1:0] MemWrData;

    modport master (
        output MemAddr,
        output MemWrEn,
        output MemWrData,
        input  MemRdData
    );

    modport slave (
        input  MemAddr,
        input  MemWrEn,
        input  MemWrData,
        output MemRdData
    );
endinterface

// File: rtl/ham_scan_ctrl_popcount.sv
// ham_popcount: combinational Hamming distance between two DW-bit words.
// Ports: a, b (DW bits in), cnt (hw_of(DW) bits out) = popcount(a ^ b).
module ham_popcount
    import ham_scan_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0]          a,
    input  logic [DW-1:0]          b,
    output logic [hw_of(DW)-1:0]   cnt
);
    localparam int HW = hw_of(DW);

    logic [DW-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DW; k++) begin
            cnt = cnt + HW'(diff[k]);
        end
    end
endmodule

// File: rtl/ham_scan_ctrl.sv
// ham_scan_ctrl: scans COUNT bytes at BASE, finds the maximum pairwise
// Hamming distance over all pairs i<j and writes it, zero-extended, to
// RESULT_ADDR. Owns the memory port while Busy=1.
// Ports: CLK, Reset (async, active-high), Start (pulse, seen in IDLE/DONE),
//        mem (ham_scan_ctrl_if.master), Busy, Done, MaxHam, IdxI, IdxJ.
// Optional macro HAM_SCAN_EARLY_EXIT_EN: stop scanning once a pair at the
// full distance DW is found (same result, shorter latency).
//
// state  | meaning
// IDLE   | waiting for Start after reset
// LOAD_I | read operand i into A
// CMP    | compare A with operand j, track first strict maximum
// WRITE  | one-cycle write of the result to RESULT_ADDR
// DONE   | result held, Done=1, waiting for Start
module ham_scan_ctrl
    import ham_scan_pkg::*;
#(
    parameter int BASE        = BASE_DEF,
    parameter int COUNT       = COUNT_DEF,
    parameter int RESULT_ADDR = RESULT_ADDR_DEF,
    parameter int AW          = 8,
    parameter int DW          = 8
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   Start,
    ham_scan_ctrl_if.master        mem,
    output logic                   Busy,
    output logic                   Done,
    output logic [hw_of(DW)-1:0]   MaxHam,
    output logic [AW-1:0]          IdxI,
    output logic [AW-1:0]          IdxJ
);
    localparam int            HW     = hw_of(DW);
    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [AW-1:0] RES_A  = AW'(RESULT_ADDR);
    // Index of the last operand; unused for COUNT<2 since that path skips the scan.
    localparam logic [AW-1:0] LAST   = AW'((COUNT < 2) ? 0 : COUNT - 1);

    if ((COUNT < 0) || (COUNT > 255) || (BASE + COUNT - 1 > (1 << AW) - 1)) begin : g_range_err
        $error("ham_scan_ctrl: operand block BASE..BASE+COUNT-1 does not fit the address space");
    end

    state_t        state;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [DW-1:0] a;
    logic [HW-1:0] d;
    logic          upd;
    logic [HW-1:0] max_nx;
    logic          early_exit;

    ham_popcount #(.DW(DW)) u_popcount (
        .a   (a),
        .b   (mem.MemRdData),
        .cnt (d)
    );

    // Strictly greater keeps the earliest pair on ties.
    assign upd    = (d > MaxHam);
    assign max_nx = upd ? d : MaxHam;

`ifdef HAM_SCAN_EARLY_EXIT_EN
    assign early_exit = (max_nx == HW'(DW));
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            mem.MemAddr   <= '0;
            mem.MemWrEn   <= 1'b0;
            mem.MemWrData <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            MaxHam        <= '0;
            IdxI          <= BASE_A;
            IdxJ          <= BASE_A;
            i             <= '0;
            j             <= '0;
            a             <= '0;
        end else begin
            mem.MemWrEn <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        Done   <= 1'b0;
                        Busy   <= 1'b1;
                        MaxHam <= '0;
                        IdxI   <= BASE_A;
                        IdxJ   <= BASE_A;
                        i      <= '0;
                        if (COUNT < 2) begin
                            state         <= WRITE;
                            mem.MemAddr   <= RES_A;
                            mem.MemWrEn   <= 1'b1;
                            mem.MemWrData <= '0;
                        end else begin
                            state       <= LOAD_I;
                            mem.MemAddr <= BASE_A;
                        end
                    end
                end
                LOAD_I: begin
                    a           <= mem.MemRdData;
                    j           <= i + AW'(1);
                    mem.MemAddr <= BASE_A + i + AW'(1);
                    state       <= CMP;
                end
                CMP: begin
                    if (upd) begin
                        MaxHam <= d;
                        IdxI   <= BASE_A + i;
                        IdxJ   <= BASE_A + j;
                    end
                    if (early_exit || ((j == LAST) && (i + AW'(1) == LAST))) begin
                        state         <= WRITE;
                        mem.MemAddr   <= RES_A;
                        mem.MemWrEn   <= 1'b1;
                        mem.MemWrData <= DW'(max_nx);
                    end else if (j != LAST) begin
                        j           <= j + AW'(1);
                        mem.MemAddr <= BASE_A + j + AW'(1);
                    end else begin
                        i           <= i + AW'(1);
                        mem.MemAddr <= BASE_A + i + AW'(1);
                        state       <= LOAD_I;
                    end
                end
                WRITE: begin
                    state <= DONE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ham_scan_ctrl.sv
// Testbench for ham_scan_ctrl: directed and random operand blocks checked
// against a pair-enumeration reference model; includes mid-scan reset,
// ignored Start pulses and a COUNT=1 instance.
module tb_ham_scan_ctrl;
    localparam int BASE  = 128;
    localparam int COUNT = 20;
    localparam int RES   = 127;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Start1;
    logic       Busy, Done, Busy1, Done1;
    logic [3:0] MaxHam, MaxHam1;
    logic [7:0] IdxI, IdxJ, IdxI1, IdxJ1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    ham_scan_ctrl_if #(.AW(8), .DW(8)) mif ();
    ham_scan_ctrl_if #(.AW(8), .DW(8)) mif1 ();

    ham_scan_ctrl #(.BASE(BASE), .COUNT(COUNT), .RESULT_ADDR(RES), .AW(8), .DW(8)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .mem(mif),
        .Busy(Busy), .Done(Done), .MaxHam(MaxHam), .IdxI(IdxI), .IdxJ(IdxJ)
    );

    ham_scan_ctrl #(.BASE(BASE), .COUNT(1), .RESULT_ADDR(RES), .AW(8), .DW(8)) dut1 (
        .CLK(CLK), .Reset(Reset), .Start(Start1), .mem(mif1),
        .Busy(Busy1), .Done(Done1), .MaxHam(MaxHam1), .IdxI(IdxI1), .IdxJ(IdxJ1)
    );

    // Memory models: combinational read, clocked write, bench preload via img.
    logic [7:0] img  [256];
    logic [7:0] mem  [256];
    logic [7:0] mem1 [256];
    logic       load_req;
    int         wr_cnt  = 0;
    int         wr1_cnt = 0;

    assign mif.MemRdData  = mem[mif.MemAddr];
    assign mif1.MemRdData = mem1[mif1.MemAddr];

    always @(posedge CLK) begin
        if (load_req) begin
            for (int k = 0; k < 256; k++) begin
                mem[k]  <= img[k];
                mem1[k] <= img[k];
            end
        end else begin
            if (mif.MemWrEn) begin
                mem[mif.MemAddr] <= mif.MemWrData;
                if (mif.MemAddr == 8'(RES)) wr_cnt <= wr_cnt + 1;
            end
            if (mif1.MemWrEn) begin
                mem1[mif1.MemAddr] <= mif1.MemWrData;
                if (mif1.MemAddr == 8'(RES)) wr1_cnt <= wr1_cnt + 1;
            end
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_img();
        load_req = 1'b1;
        @(posedge CLK);
        #1;
        load_req = 1'b0;
    endtask

    // Reference: enumerate pairs in (i,j) order, keep the first strict maximum,
    // count one cycle per operand load and per comparison, plus WRITE and DONE.
    task automatic ref_scan(output int mx, output int ii, output int jj, output int lat);
        int  d;
        bit  stop;
        mx = 0; ii = BASE; jj = BASE; lat = 0; stop = 0;
        for (int p = 0; p < COUNT - 1; p++) begin
            if (!stop) begin
                lat++;
                for (int q = p + 1; q < COUNT; q++) begin
                    if (!stop) begin
                        lat++;
                        d = $countones(img[BASE + p] ^ img[BASE + q]);
                        if (d > mx) begin
                            mx = d; ii = BASE + p; jj = BASE + q;
`ifdef HAM_SCAN_EARLY_EXIT_EN
                            if (d == 8) stop = 1;
`endif
                        end
                    end
                end
            end
        end
        lat += 2;
    endtask

    // Pulse Start, then count edges (Start edge = 1) until Done. Extra Start
    // pulses are sampled at edges g1 and g2 (0 = none).
    task automatic run_scan(input int g1, input int g2, output int lat, output int busy);
        bit seen;
        seen = 0; lat = 0; busy = 0;
        Start = 1'b1;
        for (int c = 1; c <= 2000 && !seen; c++) begin
            @(posedge CLK);
            #1;
            Start = (c == g1 - 1) || (c == g2 - 1);
            if (Busy) busy++;
            if (Done) begin
                seen = 1;
                lat  = c;
            end
        end
        Start = 1'b0;
        if (!seen) check_val("done_timeout", 0, 1);
    endtask

    task automatic scan_and_check(input string tag, input int g1, input int g2);
        int mx, ii, jj, lat_exp, lat, busy, wr0;
        ref_scan(mx, ii, jj, lat_exp);
        wr0 = wr_cnt;
        run_scan(g1, g2, lat, busy);
        #1;
        check_val({tag, "_latency"}, lat, lat_exp);
        check_val({tag, "_busy_cycles"}, busy, lat_exp - 1);
        check_val({tag, "_maxham"}, int'(MaxHam), mx);
        check_val({tag, "_idxi"}, int'(IdxI), ii);
        check_val({tag, "_idxj"}, int'(IdxJ), jj);
        check_val({tag, "_mem_result"}, int'(mem[RES]), mx);
        check_val({tag, "_write_count"}, wr_cnt - wr0, 1);
    endtask

    task automatic clear_img(input logic [7:0] res_fill);
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        img[RES] = res_fill;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat1, wr0, wr10, mx, ii, jj, lat_exp;
        bit seen;
        Reset = 1'b1; Start = 1'b0; Start1 = 1'b0; load_req = 1'b0;
        clear_img(8'hFF);
        load_img();
        @(posedge CLK);
        #1;
        check_val("rst_busy", int'(Busy), 0);
        check_val("rst_done", int'(Done), 0);
        check_val("rst_maxham", int'(MaxHam), 0);
        check_val("rst_idxi", int'(IdxI), BASE);
        check_val("rst_idxj", int'(IdxJ), BASE);
        check_val("rst_memaddr", int'(mif.MemAddr), 0);
        check_val("rst_wren", int'(mif.MemWrEn), 0);
        check_val("rst_wrdata", int'(mif.MemWrData), 0);
        Reset = 1'b0;
        @(posedge CLK);
        #1;

        // All-zero operands
        scan_and_check("zeros", 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        check_val("done_hold", int'(Done), 1);
        check_val("done_hold_wren", int'(mif.MemWrEn), 0);

        // Complementary pair in the middle of the block
        clear_img(8'hFF);
        img[135] = 8'h12; img[140] = 8'hED;
        load_img();
        scan_and_check("full_dist", 0, 0);

        // Single distinct pair at the start
        clear_img(8'hFF);
        img[128] = 8'h24; img[129] = 8'h81;
        load_img();
        scan_and_check("first_pair", 0, 0);

        // Ties: several pairs share the maximum; the earliest must win
        clear_img(8'hFF);
        img[130] = 8'h0F; img[133] = 8'hF0; img[136] = 8'h0F; img[140] = 8'hF0;
        load_img();
        scan_and_check("ties", 0, 0);

        // Reset partway through a scan
        clear_img(8'hAA);
        img[135] = 8'h12; img[140] = 8'hED;
        load_img();
        wr0 = wr_cnt;
        Start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge CLK);
            #1;
            Start = 1'b0;
        end
        Reset = 1'b1;
        #1;
        check_val("midrst_busy", int'(Busy), 0);
        check_val("midrst_done", int'(Done), 0);
        check_val("midrst_maxham", int'(MaxHam), 0);
        check_val("midrst_idxi", int'(IdxI), BASE);
        check_val("midrst_idxj", int'(IdxJ), BASE);
        check_val("midrst_wren", int'(mif.MemWrEn), 0);
        check_val("midrst_memaddr", int'(mif.MemAddr), 0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check_val("midrst_no_write", wr_cnt - wr0, 0);
        check_val("midrst_mem_kept", int'(mem[RES]), 8'hAA);
        scan_and_check("after_rst", 0, 0);

        // Start pulses while busy are ignored
        clear_img(8'hFF);
        for (int k = 0; k < COUNT; k++) img[BASE + k] = 8'($urandom_range(0, 255));
        load_img();
        scan_and_check("restart_ign", 5, 100);

        // Random operand blocks, sometimes seeded with a complementary pair
        for (int t = 0; t < 6; t++) begin
            int p, q;
            clear_img(8'($urandom_range(0, 255)));
            for (int k = 0; k < COUNT; k++) img[BASE + k] = 8'($urandom_range(0, 255));
            if (t % 2 == 1) begin
                p = $urandom_range(0, COUNT - 2);
                q = $urandom_range(p + 1, COUNT - 1);
                img[BASE + q] = ~img[BASE + p];
            end
            load_img();
            scan_and_check($sformatf("rand%0d", t), 0, 0);
        end

        // COUNT=1 instance: straight to WRITE
        clear_img(8'hFF);
        load_img();
        wr10 = wr1_cnt;
        seen = 0; lat1 = 0;
        Start1 = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge CLK);
            #1;
            Start1 = 1'b0;
            if (Done1) begin
                seen = 1;
                lat1 = c;
            end
        end
        if (!seen) check_val("c1_done_timeout", 0, 1);
        #1;
        check_val("c1_latency", lat1, 2);
        check_val("c1_mem_result", int'(mem1[RES]), 0);
        check_val("c1_maxham", int'(MaxHam1), 0);
        check_val("c1_write_count", wr1_cnt - wr10, 1);
        check_val("c1_busy", int'(Busy1), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
